// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer for the single-channel PWM generator.
// Ramps DC between latched min/max in steps, dwelling hold_eff PWM periods per level.
module pwm_fade_ctrl #(
  parameter int TPWM  = 10,
  parameter int HOLDW = 8,
  localparam int NDC  = $clog2(TPWM + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [NDC-1:0]   dc_min,
  input  logic [NDC-1:0]   dc_max,
  input  logic [NDC-1:0]   step,
  input  logic [HOLDW-1:0] hold,
  output logic [NDC-1:0]   DC,
  output logic             period_tick,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int PW = (TPWM > 1) ? $clog2(TPWM) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TPWM - 1);
  localparam logic [NDC:0]  TMAX  = (NDC + 1)'(TPWM);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [HOLDW-1:0] hcnt_q, hcnt_d;
  logic [HOLDW-1:0] lhold_q, lhold_d;
  logic [NDC-1:0]   lmin_q, lmin_d, lmax_q, lmax_d, lstep_q, lstep_d;
  logic [NDC-1:0]   dc_q, dc_d;
  logic             lloop_q, lloop_d;
  logic             done_q, done_d, err_q, err_d;

  logic             tick, step_pt;
  logic [NDC:0]     up_sum, dn_floor;
  logic [NDC-1:0]   dc_up, dc_dn;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      lhold_q <= '0;
      lmin_q  <= '0;
      lmax_q  <= '0;
      lstep_q <= '0;
      lloop_q <= 1'b0;
      dc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      lhold_q <= lhold_d;
      lmin_q  <= lmin_d;
      lmax_q  <= lmax_d;
      lstep_q <= lstep_d;
      lloop_q <= lloop_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    tick     = (state_q != IDLE) && (pcnt_q == PLAST);
    step_pt  = tick && (hcnt_q == lhold_q - HOLDW'(1));
    // Saturating level arithmetic done one bit wider so neither direction can wrap.
    up_sum   = {1'b0, dc_q} + {1'b0, lstep_q};
    dn_floor = {1'b0, lmin_q} + {1'b0, lstep_q};
    dc_up    = (up_sum > {1'b0, lmax_q}) ? lmax_q : up_sum[NDC-1:0];
    dc_dn    = ({1'b0, dc_q} < dn_floor) ? lmin_q : dc_q - lstep_q;

    state_d = state_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    lhold_d = lhold_q;
    lmin_d  = lmin_q;
    lmax_d  = lmax_q;
    lstep_d = lstep_q;
    lloop_d = lloop_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (stop) begin
      state_d = IDLE;
      dc_d    = '0;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if ((dc_min > dc_max) || ({1'b0, dc_max} > TMAX)) begin
              err_d = 1'b1;
            end else begin
              lmin_d  = dc_min;
              lmax_d  = dc_max;
              lstep_d = (step == '0) ? NDC'(1) : step;
              lhold_d = (hold == '0) ? HOLDW'(1) : hold;
              lloop_d = loop_en;
              dc_d    = dc_min;
              state_d = UP;
              pcnt_d  = '0;
              hcnt_d  = '0;
            end
          end
        end
        UP, DOWN: begin
          pcnt_d = tick ? '0 : pcnt_q + PW'(1);
          if (tick) hcnt_d = step_pt ? '0 : hcnt_q + HOLDW'(1);
          if (step_pt) begin
            if (state_q == UP) begin
              if (dc_q == lmax_q) begin
                state_d = DOWN;
                dc_d    = dc_dn;
              end else begin
                dc_d = dc_up;
              end
            end else if (dc_q == lmin_q) begin
              if (lloop_q) begin
                state_d = UP;
                dc_d    = dc_up;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              dc_d = dc_dn;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    DC          = dc_q;
    busy        = (state_q != IDLE);
    period_tick = tick;
    done        = done_q;
    cfg_err     = err_q;
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: expected DC is a precomputed list of
// levels, each expected for hold_eff*TPWM clocks after an accepted start.
module tb_pwm_fade_ctrl;

  localparam int TPWM  = 10;
  localparam int HOLDW = 8;
  localparam int NDC   = $clog2(TPWM + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             start, stop, loop_en;
  logic [NDC-1:0]   dc_min, dc_max, step;
  logic [HOLDW-1:0] hold;
  logic [NDC-1:0]   DC;
  logic             period_tick, busy, done, cfg_err;

  int tests = 0;
  int fails = 0;
  int last_dc = 0;

  pwm_fade_ctrl #(.TPWM(TPWM), .HOLDW(HOLDW)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .dc_min(dc_min), .dc_max(dc_max), .step(step), .hold(hold),
    .DC(DC), .period_tick(period_tick), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic junk_cfg();
    dc_min  = NDC'($urandom_range(0, 15));
    dc_max  = NDC'($urandom_range(0, 15));
    step    = NDC'($urandom_range(0, 15));
    hold    = HOLDW'($urandom_range(0, 255));
    loop_en = 1'($urandom_range(0, 1));
  endtask

  task automatic check_idle(input string tag, input int exp_dc);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".dc"}, int'(DC), exp_dc);
    check({tag, ".tick"}, int'(period_tick), 0);
    check({tag, ".done"}, int'(done), 0);
  endtask

  // One fade run; loop runs are stopped after ncyc clocks.
  task automatic run(input int mn, input int mx, input int st, input int ho,
                     input bit lp, input int ncyc);
    int lev[$];
    int s, h, lvl, n, per;
    s = (st == 0) ? 1 : st;
    h = (ho == 0) ? 1 : ho;
    per = h * TPWM;
    lvl = mn;
    lev.push_back(lvl);
    while (lvl != mx) begin lvl = (lvl + s > mx) ? mx : lvl + s; lev.push_back(lvl); end
    do begin
      lvl = mx;
      do begin lvl = (lvl - s < mn) ? mn : lvl - s; lev.push_back(lvl); end while (lvl != mn);
      if (!lp) break;
      while (lvl != mx) begin lvl = (lvl + s > mx) ? mx : lvl + s; lev.push_back(lvl); end
    end while (lev.size() * per <= ncyc);
    n = lp ? ncyc : lev.size() * per;

    @(negedge clock);
    dc_min = NDC'(mn); dc_max = NDC'(mx); step = NDC'(st); hold = HOLDW'(ho);
    loop_en = lp; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    junk_cfg();
    for (int c = 0; c < n; c++) begin
      check("dc", int'(DC), lev[c / per]);
      check("busy", int'(busy), 1);
      check("tick", int'(period_tick), (c % TPWM == TPWM - 1) ? 1 : 0);
      check("done", int'(done), 0);
      check("err", int'(cfg_err), 0);
      start = (lp && c == 15);
      if (start) junk_cfg();
      @(negedge clock);
    end
    start = 1'b0;
    if (lp) begin
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      check_idle("stop", 0);
      last_dc = 0;
    end else begin
      check("end.busy", int'(busy), 0);
      check("end.done", int'(done), 1);
      check("end.dc", int'(DC), mn);
      check("end.tick", int'(period_tick), 0);
      @(negedge clock);
      check_idle("post", mn);
      last_dc = mn;
    end
  endtask

  task automatic reject(input int mn, input int mx);
    @(negedge clock);
    dc_min = NDC'(mn); dc_max = NDC'(mx); step = 1; hold = 1; loop_en = 0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("rej.err", int'(cfg_err), 1);
    check_idle("rej", last_dc);
    @(negedge clock);
    check("rej.err2", int'(cfg_err), 0);
    check_idle("rej2", last_dc);
  endtask

  task automatic start_cfg(input int mn, input int mx, input int st, input int ho);
    @(negedge clock);
    dc_min = NDC'(mn); dc_max = NDC'(mx); step = NDC'(st); hold = HOLDW'(ho);
    loop_en = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    dc_min = '0; dc_max = '0; step = '0; hold = '0; loop_en = 1'b0;
    repeat (2) @(negedge clock);
    check_idle("rst", 0);
    check("rst.err", int'(cfg_err), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_idle("idle", 0);

    run(2, 6, 2, 1, 1'b0, 0);
    run(2, 6, 2, 1, 1'b1, 80);
    run(1, 7, 4, 3, 1'b0, 0);
    run(0, 2, 0, 0, 1'b0, 0);
    run(4, 4, 3, 2, 1'b0, 0);
    run(0, 10, 3, 1, 1'b0, 0);

    reject(5, 3);
    reject(0, 11);
    reject(15, 15);

    // Abort: start and stop in the same cycle mid-fade.
    start_cfg(2, 6, 2, 1);
    repeat (22) @(negedge clock);
    start = 1'b1; stop = 1'b1; junk_cfg();
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    check_idle("abort", 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      check("abort.done", int'(done), 0);
      check("abort.busy", int'(busy), 0);
    end
    last_dc = 0;
    run(3, 9, 3, 2, 1'b0, 0);

    // Asynchronous reset pulse between clock edges mid-fade.
    start_cfg(1, 7, 2, 2);
    repeat (37) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_idle("areset", 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      check_idle("after_rst", 0);
    end
    last_dc = 0;

    for (int r = 0; r < 12; r++) begin
      int mn, mx;
      mn = $urandom_range(0, TPWM);
      mx = $urandom_range(mn, TPWM);
      run(mn, mx, $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          $urandom_range(40, 300));
    end
    reject(TPWM, $urandom_range(0, TPWM - 1));
    reject($urandom_range(0, TPWM), $urandom_range(TPWM + 1, 15));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
